alu_div_seq: RTL and testbench

//  Sequential restoring divider; the inverse of the ALU multiply path.

---
 rtl/alu_div_seq_pkg.sv | 24 ++
 rtl/alu_div_seq_step.sv | 30 +++
 rtl/alu_div_seq.sv | 132 +++++++++++++
 tb/tb_alu_div_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_div_seq_pkg
// Description : Shared ALU op codes, widths and divider state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_div_seq_pkg;

    localparam int c_dividend_w = 8;
    localparam int c_divisor_w  = 4;

    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_mul = 2'b01;
    localparam logic [1:0] c_op_mod = 2'b10;
    localparam logic [1:0] c_op_and = 2'b11;

    typedef logic [1:0] div_state_t;

    localparam div_state_t c_st_idle = 2'd0;
    localparam div_state_t c_st_calc = 2'd1;
    localparam div_state_t c_st_done = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_div_seq_step.sv
`default_nettype none
// ============================================================================
// Module      : alu_div_step
// Description : Combinational single-bit restoring division stage.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div_step
    import alu_div_seq_pkg::*;
#(
    parameter int DIVISOR_W = c_divisor_w
) (
    input  logic [DIVISOR_W-1:0] rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] w_trial;

    // The restored remainder always fits DIVISOR_W bits, so the subtraction
    // can be done modulo 2**DIVISOR_W on the low bits of the trial value.
    always_comb begin
        w_trial = {rem_in, bit_in};
        q_bit   = (w_trial >= {1'b0, divisor});
        rem_out = q_bit ? (w_trial[DIVISOR_W-1:0] - divisor) : w_trial[DIVISOR_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/alu_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_div_seq
// Description : Sequential restoring divider, one quotient bit per clock,
//               with start/done handshake and divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div_seq
    import alu_div_seq_pkg::*;
#(
    parameter int DIVIDEND_W = c_dividend_w,
    parameter int DIVISOR_W  = c_divisor_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int                c_cnt_w    = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(DIVIDEND_W - 1);

    div_state_t            r_state;
    div_state_t            w_state_nxt;
    logic                  w_accept;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W-1:0]  w_rem_nxt;
    logic                  w_q_bit;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_by_zero;

    alu_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (r_rem),
        .bit_in  (r_dvd[r_cnt]),
        .divisor (r_dvs),
        .rem_out (w_rem_nxt),
        .q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (divisor == '0) ? c_st_done : c_st_calc;
                end
            end
            c_st_calc: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                done = 1'b1;
                // Back-to-back accept straight out of DONE, no idle gap.
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (divisor == '0) ? c_st_done : c_st_calc;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_dvd         <= '0;
            r_dvs         <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_dvd         <= dividend;
            r_dvs         <= divisor;
            r_cnt         <= c_cnt_init;
            r_rem         <= '0;
            r_q           <= '0;
            r_div_by_zero <= 1'b0;
            if (divisor == '0) begin
                r_quotient    <= '1;
                r_remainder   <= '0;
                r_div_by_zero <= 1'b1;
            end
        end else if (r_state == c_st_calc) begin
            r_rem        <= w_rem_nxt;
            r_q[r_cnt]   <= w_q_bit;
            r_cnt        <= r_cnt - 1'b1;
            // Last bit: publish results directly, r_q[0] is still clear here.
            if (r_cnt == '0) begin
                r_quotient  <= r_q | DIVIDEND_W'(w_q_bit);
                r_remainder <= w_rem_nxt;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_div_seq
// Description : Self-checking bench for alu_div_seq (vector table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_div_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
        logic       bsy;
    } vec_t;

    vec_t vecs[9];

    alu_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; counts edges until done is seen.
    task automatic wait_done(output int cyc, output bit busy_hi);
        cyc     = 0;
        busy_hi = 1'b0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) busy_hi = 1'b1;
            step();
            cyc++;
        end
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_div(input logic [7:0] a, input logic [3:0] b, output int lat, output bit busy_hi);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        wait_done(lat, busy_hi);
    endtask

    initial begin
        int          lat;
        bit          bh;
        logic [17:0] got_w;
        logic [17:0] exp_w;

        vecs[0] = '{8'd140, 4'd10, 8'd14,  4'd0,  1'b0, 8, 1'b1};
        vecs[1] = '{8'd3,   4'd2,  8'd1,   4'd1,  1'b0, 8, 1'b1};
        vecs[2] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 8, 1'b1};
        vecs[3] = '{8'd200, 4'd15, 8'd13,  4'd5,  1'b0, 8, 1'b1};
        vecs[4] = '{8'd12,  4'd0,  8'hFF,  4'd0,  1'b1, 0, 1'b0};
        vecs[5] = '{8'd0,   4'd7,  8'd0,   4'd0,  1'b0, 8, 1'b1};
        vecs[6] = '{8'd7,   4'd9,  8'd0,   4'd7,  1'b0, 8, 1'b1};
        vecs[7] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 8, 1'b1};
        vecs[8] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 8, 1'b1};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 4'd0;
        #1;
        chk("reset_busy",  32'(busy),        32'd0);
        chk("reset_done",  32'(done),        32'd0);
        chk("reset_quot",  32'(quotient),    32'd0);
        chk("reset_rem",   32'(remainder),   32'd0);
        chk("reset_dbz",   32'(div_by_zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_div(vecs[i].a, vecs[i].b, lat, bh);
            chk($sformatf("vec%0d_quot", i),    32'(quotient),    32'(vecs[i].q));
            chk($sformatf("vec%0d_rem", i),     32'(remainder),   32'(vecs[i].r));
            chk($sformatf("vec%0d_dbz", i),     32'(div_by_zero), 32'(vecs[i].z));
            chk($sformatf("vec%0d_latency", i), 32'(lat),         32'(vecs[i].lat));
            chk($sformatf("vec%0d_busy", i),    32'(bh),          32'(vecs[i].bsy));
            step();
            chk($sformatf("vec%0d_pulse", i),   32'(done),        32'd0);
        end

        // start re-pulsed mid-CALC must be ignored
        start    = 1'b1;
        dividend = 8'd140;
        divisor  = 4'd10;
        step();
        start = 1'b0;
        step();
        step();
        start    = 1'b1;
        dividend = 8'd3;
        divisor  = 4'd2;
        step();
        start = 1'b0;
        wait_done(lat, bh);
        chk("restart_latency", 32'(lat),       32'd5);
        chk("restart_quot",    32'(quotient),  32'd14);
        chk("restart_rem",     32'(remainder), 32'd0);

        // back-to-back accept in the DONE cycle
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd15;
        step();
        start = 1'b0;
        chk("b2b_done_low", 32'(done),     32'd0);
        chk("b2b_busy",     32'(busy),     32'd1);
        chk("b2b_held",     32'(quotient), 32'd14);
        wait_done(lat, bh);
        chk("b2b_latency", 32'(lat),       32'd8);
        chk("b2b_quot",    32'(quotient),  32'd13);
        chk("b2b_rem",     32'(remainder), 32'd5);
        step();

        // asynchronous reset four cycles into CALC
        start    = 1'b1;
        dividend = 8'd255;
        divisor  = 4'd1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy),        32'd0);
        chk("arst_done", 32'(done),        32'd0);
        chk("arst_quot", 32'(quotient),    32'd0);
        chk("arst_rem",  32'(remainder),   32'd0);
        chk("arst_dbz",  32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("arst_idle", 32'(busy), 32'd0);
        run_div(8'd3, 4'd2, lat, bh);
        chk("arst_after_quot",    32'(quotient),  32'd1);
        chk("arst_after_rem",     32'(remainder), 32'd1);
        chk("arst_after_latency", 32'(lat),       32'd8);
        step();

        // full operand sweep against a reference division
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_div(8'(ia), 4'(ib), lat, bh);
                got_w = {quotient, remainder, div_by_zero, 4'(lat), 1'b0};
                step();
                got_w[0] = done;
                if (ib != 0)
                    exp_w = {8'(ia / ib), 4'(ia % ib), 1'b0, 4'd8, 1'b0};
                else
                    exp_w = {8'hFF, 4'd0, 1'b1, 4'd0, 1'b0};
                chk($sformatf("sweep_%0d_div_%0d", ia, ib), 32'(got_w), 32'(exp_w));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
